d_grf_mp: RTL and testbench
===========================

D_GRF_MP -- requirements
Module: d_grf_mp

Interface
REQ-001 SHALL provide parameters: DW, default 32, data width; AW, default 5, address width, depth 2^AW; NR, default 2, number of read ports.
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have the ports ra, input, NR*AW bits: read addresses, port k at bits [k*AW +: AW].
REQ-005 SHALL have the ports rd, output, NR*DW bits: read data, port k at bits [k*DW +: DW].
REQ-006 SHALL have the port rpend, output, NR bits: pending (scoreboard) flag per read port.
REQ-007 SHALL have the ports we0, wa0 and wd0: input, 1/AW/DW bits: write port 0, the older pipeline stage.
REQ-008 SHALL have the ports we1, wa1 and wd1: input, 1/AW/DW bits: write port 1, the younger stage, with priority over port 0.
REQ-009 SHALL have the ports iss_en and iss_a: input, 1/AW bits: issue of a new producer for register iss_a.
REQ-010 SHALL have the port wcnt, output, 32 bits: count of committed register writes.

Function
REQ-011 SHALL hold 2^AW registers of DW bits; register 0 SHALL read 0, SHALL ignore writes and SHALL never be pending.
REQ-012 A write on port p SHALL be effective when wep=1 and wap!=0; the register SHALL update at the next posedge.
REQ-013 If both write ports are effective to the same address, the register SHALL take wd1 and wd0 SHALL be discarded.
REQ-014 Read SHALL be combinational with same-cycle bypass, in this priority: effective port-1 match gives wd1; else effective port-0 match gives wd0; else the array value; ra=0 SHALL give 0 regardless.
REQ-015 SHALL keep a pending bit per register; iss_en=1 with iss_a!=0 SHALL set pend[iss_a] at the next posedge.
REQ-016 An effective write SHALL clear pend[wa] at the next posedge.
REQ-017 If a set and a clear hit the same address in one cycle, the set SHALL win and pend SHALL be 1.
REQ-018 rpend[k] SHALL be pend[ra_k] after bypass: 0 if an effective write to ra_k occurs in the same cycle and no same-cycle issue targets it; 0 for ra_k=0.
REQ-019 wcnt SHALL increment by the number of effective writes per cycle (0, 1 or 2); a same-address collision SHALL count as 2; the counter SHALL wrap modulo 2^32.
REQ-020 The read ports SHALL be independent; any number of ports may address the same register.
REQ-021 There SHALL be no handshake; every input SHALL be sampled every cycle, and there SHALL be no stall or backpressure.

Reset
REQ-022 While reset=1 at posedge: all registers SHALL become 0, all pend SHALL become 0, and wcnt SHALL become 0; writes and issues in that cycle SHALL be ignored.
REQ-023 During a reset cycle, rd SHALL still bypass the same-cycle write data combinationally, but that data SHALL NOT be stored.
REQ-024 All registers SHALL also be 0 at time zero, before any reset, for simulation.

Verification
REQ-025 Reset, then read all 32 addresses on both ports -> rd=0 everywhere, rpend=0, wcnt=0.
REQ-026 we0=1, wa0=5, wd0=0x1234 with ra0=5 in the same cycle -> rd0=0x1234 in that cycle; next cycle array read gives rd0=0x1234; wcnt=1.
REQ-027 we0=1, wa0=7, wd0=0xAAAA and we1=1, wa1=7, wd1=0xBBBB in one cycle -> same-cycle rd=0xBBBB; stored value 0xBBBB; wcnt +2.
REQ-028 iss_en=1, iss_a=3, then the next cycle we1=1, wa1=3 with iss_en=1, iss_a=3 -> rpend(3)=1 after the issue; still 1 after the set/clear collision; write-only cycle -> 0.
REQ-029 we0=1, wa0=0, wd0=0xFFFF, iss_en=1, iss_a=0 -> rd(0)=0, rpend(0)=0, wcnt unchanged.
REQ-030 Preload wcnt to 0xFFFFFFFF via writes (or force), then two effective writes -> wcnt=1; assert reset mid-sequence with pending bits set -> all pend and wcnt = 0 the next cycle.

Source files
------------

// File: rtl/d_grf_mp.sv
// d_grf_mp: multi-port register file with scoreboard pending bits and write counter
//
// Ports:
//   clk            - single clock, all state updates on posedge
//   reset          - synchronous active-high reset (clears registers, pending bits, wcnt)
//   ra  [NR*AW]    - read addresses, port k at [k*AW +: AW]
//   rd  [NR*DW]    - combinational read data with same-cycle write bypass
//   rpend [NR]     - pending flag of the addressed register, after write bypass
//   we0/wa0/wd0    - write port 0 (older stage)
//   we1/wa1/wd1    - write port 1 (younger stage, wins on address collision)
//   iss_en/iss_a   - issue of a new producer, marks register iss_a pending
//   wcnt [32]      - running count of committed register writes (wraps)
module d_grf_mp #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rpend,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_a,
    output logic [31:0]      wcnt
);
    localparam int DEPTH = 2**AW;

    // Zero at time zero so reads before the first reset are defined in simulation.
    logic [DW-1:0]    regs [DEPTH] = '{default: '0};
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             eff0;
    logic             eff1;
    logic             iss_eff;

    // Register 0 is hardwired: writes and issues to it are not effective.
    assign eff0    = we0 && wa0 != '0;
    assign eff1    = we1 && wa1 != '0;
    assign iss_eff = iss_en && iss_a != '0;

    // Writes clear pending bits; a same-cycle issue to the same address wins.
    always_comb begin
        pend_nxt = pend;
        if (eff0) pend_nxt[wa0] = 1'b0;
        if (eff1) pend_nxt[wa1] = 1'b0;
        if (iss_eff) pend_nxt[iss_a] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend <= '0;
            wcnt <= '0;
        end else begin
            // Port 1 is written last so it overrides port 0 on a collision.
            if (eff0) regs[wa0] <= wd0;
            if (eff1) regs[wa1] <= wd1;
            pend <= pend_nxt;
            wcnt <= wcnt + {31'b0, eff0} + {31'b0, eff1};
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          wr_hit;
        logic          iss_hit;
        assign a       = ra[k*AW +: AW];
        assign wr_hit  = (eff1 && wa1 == a) || (eff0 && wa0 == a);
        assign iss_hit = iss_eff && iss_a == a;
        assign rd[k*DW +: DW] = a == '0             ? '0  :
                                eff1 && wa1 == a    ? wd1 :
                                eff0 && wa0 == a    ? wd0 :
                                regs[a];
        // A same-cycle write resolves the hazard unless a new producer is issued too.
        assign rpend[k] = a != '0 && pend[a] && !(wr_hit && !iss_hit);
    end
endmodule

// File: tb/tb_d_grf_mp.sv
// tb_d_grf_mp: directed self-checking bench for d_grf_mp
module tb_d_grf_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rpend;
    logic             we0, we1, iss_en;
    logic [AW-1:0]    wa0, wa1, iss_a;
    logic [DW-1:0]    wd0, wd1;
    logic [31:0]      wcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    d_grf_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rpend(rpend),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_a(iss_a), .wcnt(wcnt)
    );

    task automatic clear_in();
        we0 = 0; wa0 = 0; wd0 = 0;
        we1 = 0; wa1 = 0; wd1 = 0;
        iss_en = 0; iss_a = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_in(); ra = '0;
        tick();
        reset = 0;
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            checks++;
            if (rd !== '0) begin
                errors++;
                $display("FAIL reset_rd addr=%0d got=%h exp=0", a, rd);
            end
            checks++;
            if (rpend !== 2'b00) begin
                errors++;
                $display("FAIL reset_rpend addr=%0d got=%b exp=00", a, rpend);
            end
        end
        checks++;
        if (wcnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_wcnt got=%0d exp=0", wcnt);
        end
    endtask

    task automatic test_bypass();
        clear_in();
        we0 = 1; wa0 = 5; wd0 = 32'h1234; ra = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_p0 got=%h exp=1234", rd[31:0]);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (rd[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL stored_p0 got=%h exp=1234", rd[31:0]);
        end
        checks++;
        if (wcnt !== 32'd1) begin
            errors++;
            $display("FAIL bypass_wcnt got=%0d exp=1", wcnt);
        end
    endtask

    task automatic test_collision();
        clear_in();
        we0 = 1; wa0 = 7; wd0 = 32'hAAAA;
        we1 = 1; wa1 = 7; wd1 = 32'hBBBB;
        ra = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd !== {32'hBBBB, 32'hBBBB}) begin
            errors++;
            $display("FAIL coll_bypass got=%h exp=BBBB on both ports", rd);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (rd !== {32'hBBBB, 32'hBBBB}) begin
            errors++;
            $display("FAIL coll_stored got=%h exp=BBBB on both ports", rd);
        end
        checks++;
        if (wcnt !== 32'd3) begin
            errors++;
            $display("FAIL coll_wcnt got=%0d exp=3", wcnt);
        end
    endtask

    task automatic test_pending();
        clear_in();
        iss_en = 1; iss_a = 3; ra = {5'd3, 5'd3};
        tick();
        clear_in();
        #1;
        checks++;
        if (rpend !== 2'b11) begin
            errors++;
            $display("FAIL pend_after_issue got=%b exp=11", rpend);
        end
        we1 = 1; wa1 = 3; wd1 = 32'h33; iss_en = 1; iss_a = 3;
        #1;
        checks++;
        if (rpend !== 2'b11) begin
            errors++;
            $display("FAIL pend_setclr_same got=%b exp=11", rpend);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (rpend !== 2'b11) begin
            errors++;
            $display("FAIL pend_setclr_after got=%b exp=11", rpend);
        end
        we0 = 1; wa0 = 3; wd0 = 32'h44;
        #1;
        checks++;
        if (rpend !== 2'b00) begin
            errors++;
            $display("FAIL pend_wr_bypass got=%b exp=00", rpend);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (rpend !== 2'b00) begin
            errors++;
            $display("FAIL pend_cleared got=%b exp=00", rpend);
        end
        checks++;
        if (wcnt !== 32'd5) begin
            errors++;
            $display("FAIL pend_wcnt got=%0d exp=5", wcnt);
        end
        ra = {5'd7, 5'd3};
        #1;
        checks++;
        if (rd !== {32'hBBBB, 32'h44}) begin
            errors++;
            $display("FAIL indep_ports got=%h exp=0000bbbb00000044", rd);
        end
    endtask

    task automatic test_zero_reg();
        clear_in();
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF; iss_en = 1; iss_a = 0; ra = '0;
        #1;
        checks++;
        if (rd !== '0 || rpend !== 2'b00) begin
            errors++;
            $display("FAIL zero_same rd=%h rpend=%b exp=0/00", rd, rpend);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (rd !== '0 || rpend !== 2'b00) begin
            errors++;
            $display("FAIL zero_after rd=%h rpend=%b exp=0/00", rd, rpend);
        end
        checks++;
        if (wcnt !== 32'd5) begin
            errors++;
            $display("FAIL zero_wcnt got=%0d exp=5", wcnt);
        end
    endtask

    task automatic test_wrap();
        clear_in();
        force dut.wcnt = 32'hFFFF_FFFF;
        #1;
        release dut.wcnt;
        #1;
        checks++;
        if (wcnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got=%h exp=ffffffff", wcnt);
        end
        we0 = 1; wa0 = 1; wd0 = 32'h1;
        we1 = 1; wa1 = 2; wd1 = 32'h2;
        tick();
        clear_in();
        #1;
        checks++;
        if (wcnt !== 32'd1) begin
            errors++;
            $display("FAIL wrap_wcnt got=%0d exp=1", wcnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_in();
        iss_en = 1; iss_a = 4;
        tick();
        iss_a = 6;
        tick();
        clear_in();
        ra = {5'd6, 5'd4};
        #1;
        checks++;
        if (rpend !== 2'b11) begin
            errors++;
            $display("FAIL mid_pend_set got=%b exp=11", rpend);
        end
        reset = 1;
        we0 = 1; wa0 = 9; wd0 = 32'h99; iss_en = 1; iss_a = 9; ra = {5'd4, 5'd9};
        #1;
        checks++;
        if (rd[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL mid_reset_bypass got=%h exp=99", rd[31:0]);
        end
        tick();
        reset = 0;
        clear_in();
        #1;
        checks++;
        if (rpend !== 2'b00 || rd !== '0) begin
            errors++;
            $display("FAIL mid_reset_after rpend=%b rd=%h exp=00/0", rpend, rd);
        end
        checks++;
        if (wcnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_wcnt got=%0d exp=0", wcnt);
        end
        ra = {5'd6, 5'd6};
        #1;
        checks++;
        if (rpend !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_pend6 got=%b exp=00", rpend);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_pending();
        test_zero_reg();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
